// File: rtl/rx_capture_ctrl_if.sv
// rx_capture_ctrl bundle: sample stream in, BRAM ports A/B, frame stream out.
// master = capture controller, slave = source/BRAM/sink side.
interface rx_capture_ctrl_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 18
);
  logic [DATA_W-1:0] sample_in;
  logic              sample_valid;
  logic              arm;
  logic              trigger;
  logic              read_start;
  logic              ena;
  logic              wea;
  logic [ADDR_W-1:0] addra;
  logic [DATA_W-1:0] dia;
  logic              enb;
  logic [ADDR_W-1:0] addrb;
  logic [DATA_W-1:0] dob;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_last;
  logic              busy;
  logic              done;

  modport master (
    input  sample_in, sample_valid, arm, trigger, read_start, dob,
    output ena, wea, addra, dia, enb, addrb,
    output out_data, out_valid, out_last, busy, done
  );

  modport slave (
    output sample_in, sample_valid, arm, trigger, read_start, dob,
    input  ena, wea, addra, dia, enb, addrb,
    input  out_data, out_valid, out_last, busy, done
  );
endinterface

// File: rtl/rx_capture_ctrl.sv
// Circular-buffer capture into a dual-port BRAM with qualified trigger,
// post-trigger count, freeze, and oldest-first frame readout.
module rx_capture_ctrl #(
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 18,
  parameter int POST_LEN = 256
) (
  input  logic               clk,
  input  logic               rst,
  rx_capture_ctrl_if.master  bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int CW    = ADDR_W + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] THRESH  = CW'(DEPTH - POST_LEN);
  localparam logic [CW-1:0] POST_C  = CW'(POST_LEN);
  localparam logic [CW-1:0] LAST_K  = CW'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_POST,
    S_DONE,
    S_READ
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [ADDR_W-1:0] addra_q;
  logic [DATA_W-1:0] dia_q;
  logic [CW-1:0]     fill_cnt_q;
  logic [CW-1:0]     post_cnt_q;
  logic [CW-1:0]     rd_cnt_q;
  logic              ena_q;
  logic              enb_q;
  logic              enb_last_q;
  logic              out_valid_q;
  logic              out_last_q;
  logic              busy_q;
  logic              done_q;

  logic              wr_en_d;
  logic              trig_ok_d;
  logic              post_end_d;
  logic [CW-1:0]     post_cnt_d;

  assign wr_en_d = bus.sample_valid &&
                   (state_q == S_PRE || state_q == S_POST);

  assign trig_ok_d = (state_q == S_PRE) && bus.trigger &&
                     (fill_cnt_q >= THRESH);

  // The acceptance-cycle sample is post-sample 1, so PRE counts from zero.
  assign post_cnt_d = ((state_q == S_POST) ? post_cnt_q : '0) +
                      CW'(wr_en_d);

  assign post_end_d = wr_en_d && (post_cnt_d == POST_C);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      addra_q     <= '0;
      dia_q       <= '0;
      fill_cnt_q  <= '0;
      post_cnt_q  <= '0;
      rd_cnt_q    <= '0;
      ena_q       <= 1'b0;
      enb_q       <= 1'b0;
      enb_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      ena_q       <= wr_en_d;
      out_valid_q <= enb_q;
      out_last_q  <= enb_last_q;
      if (wr_en_d) begin
        addra_q  <= wr_ptr_q;
        dia_q    <= bus.sample_in;
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      unique case (state_q)
        S_IDLE: begin
          if (bus.arm) begin
            state_q    <= S_PRE;
            wr_ptr_q   <= '0;
            fill_cnt_q <= '0;
            post_cnt_q <= '0;
            busy_q     <= 1'b1;
          end
        end
        S_PRE: begin
          if (wr_en_d && fill_cnt_q != DEPTH_C) begin
            fill_cnt_q <= fill_cnt_q + 1'b1;
          end
          if (trig_ok_d) begin
            post_cnt_q <= post_cnt_d;
            state_q    <= post_end_d ? S_DONE : S_POST;
            done_q     <= post_end_d;
          end
        end
        S_POST: begin
          post_cnt_q <= post_cnt_d;
          if (post_end_d) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          // wr_ptr now points at the oldest sample of the frame.
          if (bus.read_start) begin
            state_q    <= S_READ;
            done_q     <= 1'b0;
            enb_q      <= 1'b1;
            enb_last_q <= 1'b0;
            rd_ptr_q   <= wr_ptr_q;
            rd_cnt_q   <= CW'(1);
          end
        end
        S_READ: begin
          if (rd_cnt_q != DEPTH_C) begin
            enb_q      <= 1'b1;
            enb_last_q <= (rd_cnt_q == LAST_K);
            rd_ptr_q   <= rd_ptr_q + 1'b1;
            rd_cnt_q   <= rd_cnt_q + 1'b1;
          end else begin
            enb_q      <= 1'b0;
            enb_last_q <= 1'b0;
          end
          if (out_last_q) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ena       = ena_q;
  assign bus.wea       = ena_q;
  assign bus.addra     = addra_q;
  assign bus.dia       = dia_q;
  assign bus.enb       = enb_q;
  assign bus.addrb     = rd_ptr_q;
  assign bus.out_data  = out_valid_q ? bus.dob : '0;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_rx_capture_ctrl.sv
// Bench for rx_capture_ctrl: vector table, sample-level capture model,
// BRAM model and frame readout checks.
module tb_rx_capture_ctrl;
  localparam int AW    = 9;
  localparam int DW    = 18;
  localparam int PL    = 256;
  localparam int DEPTH = 512;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int first_wr = -1;
  int rd_first = -1;
  int rd_lastc = -1;
  int last_pos = -1;
  int n_last = 0;
  int fs = 0;
  int hist[$];
  int rd_q[$];
  int exp_frame[$];

  always #5 clk = ~clk;

  rx_capture_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  rx_capture_ctrl #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .POST_LEN(PL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [DW-1:0] mem [DEPTH];

  always @(posedge clk) begin
    if (bus.ena && bus.wea) mem[bus.addra] <= bus.dia;
    if (bus.enb) bus.dob <= mem[bus.addrb];
  end

  typedef struct {
    logic r;
    logic a;
    logic v;
    logic t;
    logic rs;
    logic busy;
    logic done;
    logic ena;
    logic enb;
    logic zero;
  } vec_t;

  vec_t vt[8];

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic logic any_out();
    return |{bus.ena, bus.wea, bus.addra, bus.dia, bus.enb, bus.addrb,
             bus.out_data, bus.out_valid, bus.out_last, bus.busy,
             bus.done};
  endfunction

  task automatic step(input logic v, input int d, input logic t,
                      input logic a, input logic rs);
    bus.sample_valid = v;
    bus.sample_in    = d[DW-1:0];
    bus.trigger      = t;
    bus.arm          = a;
    bus.read_start   = rs;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.ena) begin
      wr_cnt++;
      if (first_wr < 0) first_wr = int'(bus.addra);
    end
    if (bus.out_valid) begin
      if (rd_q.size() == 0) rd_first = cyc;
      rd_lastc = cyc;
      rd_q.push_back(int'(bus.out_data));
      if (bus.out_last) begin
        n_last++;
        last_pos = rd_q.size() - 1;
      end
    end
  endtask

  // vpct: valid %, or -1 for every-other-cycle in POST.
  // tmode: 0 held, 1 on sample index tparam, 2 random pulses tparam %.
  task automatic capture(input int vpct, input int tmode,
                         input int tparam, input logic seqd);
    int phase;
    int post_n;
    int idx;
    int d;
    logic v;
    logic t;
    logic acc;
    phase = 0;
    post_n = 0;
    hist.delete();
    wr_cnt = 0;
    first_wr = -1;
    step(1'b0, 0, 1'b0, 1'b1, 1'b0);
    check("arm_busy", bus.busy, 1);
    for (int c = 0; c < 6000 && phase != 2; c++) begin
      idx = hist.size();
      if (vpct < 0) v = (phase == 1) ? (c % 2 == 1) : 1'b1;
      else v = ($urandom_range(0, 99) < vpct);
      d = seqd ? idx : int'($urandom_range(0, (1 << DW) - 1));
      if (tmode == 0) t = 1'b1;
      else if (tmode == 1) t = v && (idx == tparam);
      else t = ($urandom_range(0, 99) < tparam);
      acc = (phase == 0) && t && (idx >= DEPTH - PL);
      if (v) hist.push_back(d);
      if (acc) phase = 1;
      if (phase == 1 && v) post_n++;
      if (phase == 1 && post_n == PL) phase = 2;
      step(v, d, t, 1'b0, 1'b0);
      check("done_flag", bus.done, int'(phase == 2));
      check("busy_flag", bus.busy, 1);
    end
    check("capture_end", bus.done, 1);
    check("write_count", wr_cnt, hist.size());
    check("first_wr_addr", first_wr, 0);
    exp_frame.delete();
    if (hist.size() >= DEPTH) begin
      for (int k = 0; k < DEPTH; k++)
        exp_frame.push_back(hist[hist.size() - DEPTH + k]);
    end
    fs = hist.size() % DEPTH;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, k, 1'b1, 1'b1, 1'b0);
      check("frozen_done", bus.done, 1);
    end
    check("frozen_no_write", wr_cnt, hist.size());
  endtask

  task automatic readout(input int abort_at, input logic noise);
    int w0;
    logic nv;
    logic na;
    logic nt;
    logic nr;
    w0 = wr_cnt;
    rd_q.delete();
    n_last = 0;
    last_pos = -1;
    rd_first = -1;
    rd_lastc = -1;
    step(1'b0, 0, 1'b0, 1'b0, 1'b1);
    check("rd_done_clr", bus.done, 0);
    check("rd_first_enb", bus.enb, 1);
    check("rd_frame_start", bus.addrb, fs);
    for (int i = 1; i <= 513; i++) begin
      nv = noise && ($urandom_range(0, 1) == 1);
      na = noise && ($urandom_range(0, 1) == 1);
      nt = noise && ($urandom_range(0, 1) == 1);
      nr = noise && ($urandom_range(0, 1) == 1);
      if (i == abort_at) rst = 1'b1;
      step(nv, int'($urandom_range(0, 1000)), nt, na, nr);
      if (i == abort_at) begin
        rst = 1'b0;
        check("abort_enb", bus.enb, 0);
        check("abort_out_valid", bus.out_valid, 0);
        check("abort_busy", bus.busy, 0);
        step(1'b0, 0, 1'b0, 1'b0, 1'b0);
        check("abort_idle_enb", bus.enb, 0);
        break;
      end
      if (i == 512) begin
        check("rd_out_last", bus.out_last, 1);
        check("rd_out_valid_last", bus.out_valid, 1);
      end
      if (i == 513) begin
        check("rd_busy_end", bus.busy, 0);
        check("rd_out_valid_end", bus.out_valid, 0);
      end
    end
    check("rd_no_write", wr_cnt, w0);
    if (abort_at < 0) begin
      check("rd_beats", rd_q.size(), DEPTH);
      check("rd_contiguous", rd_lastc - rd_first + 1, rd_q.size());
      check("rd_last_pos", last_pos, DEPTH - 1);
      check("rd_last_count", n_last, 1);
    end else begin
      check("abort_beats", rd_q.size(), abort_at - 1);
    end
    for (int k = 0; k < rd_q.size() && k < exp_frame.size(); k++)
      check("rd_data", rd_q[k], exp_frame[k]);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.sample_in    = '0;
    bus.sample_valid = 1'b0;
    bus.arm          = 1'b0;
    bus.trigger      = 1'b0;
    bus.read_start   = 1'b0;

    vt[0] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    for (int i = 0; i < 8; i++) begin
      rst = vt[i].r;
      step(vt[i].v, i, vt[i].t, vt[i].a, vt[i].rs);
      check("vec_busy", bus.busy, vt[i].busy);
      check("vec_done", bus.done, vt[i].done);
      check("vec_ena", bus.ena, vt[i].ena);
      check("vec_enb", bus.enb, vt[i].enb);
      if (vt[i].zero) check("vec_all_zero", any_out(), 0);
    end
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      step(1'b0, 0, 1'b0, 1'b0, 1'b0);
      check("idle_zero", any_out(), 0);
    end

    capture(100, 0, 0, 1'b1);
    readout(-1, 1'b0);

    capture(100, 1, 600, 1'b1);
    readout(-1, 1'b0);

    capture(-1, 2, 20, 1'b1);
    readout(-1, 1'b1);

    capture(70, 2, 5, 1'b0);
    readout(100, 1'b1);

    capture(60, 2, 3, 1'b0);
    readout(-1, 1'b0);

    for (int s = 0; s < 2; s++) begin
      capture(int'($urandom_range(40, 100)), 2,
              int'($urandom_range(1, 10)), 1'b0);
      readout(-1, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rx_capture_ctrl.md
# rx_capture_ctrl

Capture controller driving both ports of the 512 x 18 receive sample BRAM (`rx_BRAM`). It writes the incoming 18-bit sample stream into the RAM as a circular buffer and accepts a trigger only once enough pre-trigger history is present. It then writes `POST_LEN` further samples, freezes the buffer, and on request streams the whole frozen frame out oldest-first.

## Interface
Parameters:
- `ADDR_W`, 9, BRAM address width; depth `DEPTH = 2**ADDR_W` = 512.
- `DATA_W`, 18, sample width.
- `POST_LEN`, 256, samples written from trigger acceptance onward; legal range 1..DEPTH-1.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `sample_in`  in  DATA_W  incoming sample.
- `sample_valid`  in  1  `sample_in` valid this cycle.
- `arm`  in  1  single-cycle pulse; starts capture from IDLE.
- `trigger`  in  1  trigger event, level-sampled.
- `read_start`  in  1  single-cycle pulse; starts frame readout from DONE.
- `ena`, `wea`  out  1  BRAM port A enable / write enable (driven identically).
- `addra`  out  ADDR_W  BRAM write address.
- `dia`  out  DATA_W  BRAM write data.
- `enb`  out  1  BRAM port B read enable.
- `addrb`  out  ADDR_W  BRAM read address.
- `dob`  in  DATA_W  BRAM read data, valid 1 cycle after `enb`.
- `out_data`  out  DATA_W  readout sample (= `dob`).
- `out_valid`  out  1  `out_data` valid.
- `out_last`  out  1  with `out_valid` on the final (512th) sample.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  frame frozen, awaiting `read_start`.

## Operation
- States: IDLE, PRE, POST, DONE, READ.
- IDLE: no writes. `arm` -> PRE; clears `wr_ptr` and `fill_cnt`.
- PRE: each `sample_valid` writes `sample_in` at `wr_ptr`, then `wr_ptr` increments mod DEPTH. `fill_cnt` increments and saturates at DEPTH.
- Trigger qualification: `trigger` is accepted in PRE only when `fill_cnt >= DEPTH-POST_LEN`. Earlier triggers are ignored and not remembered.
- On acceptance: go to POST. If `sample_valid` is high in the acceptance cycle, that sample is written and counts as post-sample 1.
- POST: count valid writes. The write that makes `post_cnt == POST_LEN` is the last one; then go to DONE. `trigger` is ignored in POST.
- DONE: `done=1`, no writes. `frame_start = wr_ptr`, the oldest sample. `read_start` -> READ.
- READ: issue DEPTH reads at `frame_start+k` mod DEPTH, k = 0..DEPTH-1, one per cycle with no gaps. After the final data returns, go to IDLE.
- `arm` outside IDLE, `read_start` outside DONE, and `sample_valid` in IDLE/DONE/READ are all ignored.
- Address arithmetic is unsigned mod 2^ADDR_W; wrap 511 -> 0 is normal operation.

## Timing
- Reset: state IDLE; `wr_ptr`, `fill_cnt`, `post_cnt`, `rd_ptr` = 0. Every output is 0, including `ena`, `wea`, `enb`, `out_valid`, `out_last`, `busy`, `done`, `addra`, `addrb`, `dia`.
- `rst` mid-operation takes effect in the next cycle: abort to IDLE, no further `ena`/`enb`, `out_valid` low the next cycle. BRAM contents are not cleared.
- Write path is registered. A sample valid at cycle N gives `ena`/`wea`/`addra`/`dia` at N+1, and the RAM is updated at edge N+2.
- `arm` at N: `busy=1` at N+1. A sample valid at N+1 is the first one written.
- The final POST write is seen at N. `wea` is asserted at N+1, and `done=1` at N+1.
- `read_start` at N: `done=0` and the first `enb` at N+1, with `addrb` = `frame_start`. `enb` stays high for 512 cycles.
- `out_valid` = `enb` delayed 1 cycle; `out_data` = `dob`. `out_last` at N+513. `busy=0` at N+514.
- Throughput: 1 write/cycle and 1 read/cycle; no backpressure on either stream.

## Test plan
- Reset, then idle 10 cycles -> all outputs 0, no `ena`/`enb` pulses.
- `arm`, continuous samples 0,1,2,...; `trigger` held from the first cycle -> trigger accepted with sample 256 (fill = 256), writes stop after sample 511, `done=1`, `frame_start = 0`.
- `arm`, 700 samples with value = index, trigger at sample 600 -> last write is sample 855. Readout gives 344..855 in order, wrapping through addr 511 -> 0. `out_last` on 855.
- Trigger pulses before fill threshold, then `sample_valid` gaps every other cycle in POST -> early triggers ignored; exactly POST_LEN writes after acceptance, counted on valid cycles only.
- `read_start` in PRE, `arm` in READ, `sample_valid` during READ -> no state change and no writes; readout intact with 512 contiguous `out_valid`.
- `rst` asserted at read beat 100 -> `enb`/`out_valid` low from the next cycle, state IDLE. A new `arm` restarts cleanly with `wr_ptr` = 0.
